// File: rtl/cpu_pkg.sv
// Shared widths, field positions and the built-in program image
// for the 16-bit CPU front end.
package cpu_pkg;

    localparam int WORD_W  = 16;
    localparam int IFID_W  = 32;
    localparam int REG_CNT = 16;
    localparam int RADDR_W = $clog2(REG_CNT);

    localparam int OPC_HI  = 15;
    localparam int OPC_LO  = 12;
    localparam int RA_HI   = 11;
    localparam int RA_LO   = 8;
    localparam int RB_HI   = 7;
    localparam int RB_LO   = 4;
    localparam int FUNC_HI = 3;
    localparam int FUNC_LO = 0;

    localparam logic [WORD_W-1:0] RESET_PC = 16'h0000;
    localparam logic [WORD_W-1:0] PC_STEP  = 16'h0002;

    typedef struct packed {
        logic [WORD_W-1:0] pc_plus2;
        logic [WORD_W-1:0] instr;
    } if_id_t;

    // Program image held in the ROM; any word not listed reads as zero.
    function automatic logic [WORD_W-1:0] rom_word(int unsigned idx);
        logic [WORD_W-1:0] w;
        case (idx)
            0:       w = 16'h1120;
            1:       w = 16'h2340;
            2:       w = 16'h5670;
            default: w = 16'h0000;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/cpu_regfile.sv
// 16x16 register file: two async read ports, one sync write port,
// R0 always visible; reset loads Rn = {4{n}}.
module cpu_regfile
    import cpu_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               we_i,
    input  logic [RADDR_W-1:0] waddr_i,
    input  logic [WORD_W-1:0]  wdata_i,
    input  logic [RADDR_W-1:0] raddr1_i,
    input  logic [RADDR_W-1:0] raddr2_i,
    output logic [WORD_W-1:0]  rdata1_o,
    output logic [WORD_W-1:0]  rdata2_o,
    output logic [WORD_W-1:0]  r0_o
);

    logic [WORD_W-1:0] regs_q [REG_CNT];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < REG_CNT; i++) begin
                regs_q[i] <= {4{4'(i)}};
            end
        end else if (we_i) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata1_o = regs_q[raddr1_i];
    assign rdata2_o = regs_q[raddr2_i];
    assign r0_o     = regs_q[0];

endmodule

// File: rtl/cpu.sv
// CPU front end: PC, PC+2 adder, async ROM, IF/ID register
// and the decode-stage register file reads.
module cpu
    import cpu_pkg::*;
#(
    parameter int                ROM_WORDS  = 256,
    parameter logic [WORD_W-1:0] RESET_PC_P = RESET_PC
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic [WORD_W-1:0] PCOutput,
    output logic [WORD_W-1:0] IFAdderOutput,
    output logic [WORD_W-1:0] Instruction,
    output logic [IFID_W-1:0] IFID_Output,
    output logic [WORD_W-1:0] rd1Read,
    output logic [WORD_W-1:0] rd2Read,
    output logic [WORD_W-1:0] reg0Read
);

    localparam int AW = $clog2(ROM_WORDS);

    logic [WORD_W-1:0] pc_q;
    logic [WORD_W-1:0] pc_d;
    if_id_t            if_id_q;
    if_id_t            if_id_d;
    logic [AW-1:0]     rom_idx;

    assign pc_d    = pc_q + PC_STEP;
    // Byte-addressed PC: bit 0 ignored, fetch wraps every 2*ROM_WORDS bytes.
    assign rom_idx = pc_q[AW:1];

    always_comb begin
        if_id_d          = '0;
        if_id_d.pc_plus2 = pc_d;
        if_id_d.instr    = rom_word(32'(rom_idx));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q    <= RESET_PC_P;
            if_id_q <= '0;
        end else begin
            pc_q    <= pc_d;
            if_id_q <= if_id_d;
        end
    end

    cpu_regfile u_regfile (
        .clk_i    (clk),
        .rst_ni   (reset_n),
        .we_i     (1'b0),
        .waddr_i  ('0),
        .wdata_i  ('0),
        .raddr1_i (if_id_q.instr[RA_HI:RA_LO]),
        .raddr2_i (if_id_q.instr[RB_HI:RB_LO]),
        .rdata1_o (rd1Read),
        .rdata2_o (rd2Read),
        .r0_o     (reg0Read)
    );

    assign PCOutput      = pc_q;
    assign IFAdderOutput = pc_d;
    assign Instruction   = if_id_d.instr;
    assign IFID_Output   = if_id_q;

endmodule

// File: tb/tb_cpu.sv
// Directed bench for the CPU front end: reset, fetch/decode pipeline,
// async mid-run reset, ROM wrap and PC wrap.
module tb_cpu;

    logic        clk;
    logic        reset_n;
    logic [15:0] PCOutput;
    logic [15:0] IFAdderOutput;
    logic [15:0] Instruction;
    logic [31:0] IFID_Output;
    logic [15:0] rd1Read;
    logic [15:0] rd2Read;
    logic [15:0] reg0Read;

    int checks = 0;
    int errors = 0;

    cpu dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .PCOutput      (PCOutput),
        .IFAdderOutput (IFAdderOutput),
        .Instruction   (Instruction),
        .IFID_Output   (IFID_Output),
        .rd1Read       (rd1Read),
        .rd2Read       (rd2Read),
        .reg0Read      (reg0Read)
    );

    initial begin
        clk = 1'b0;
        forever #20 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        reset_n = 1'b1;
        #5 reset_n = 1'b0;
        @(negedge clk);
        chk("rst_pc",    32'(PCOutput),      32'h0000);
        chk("rst_add",   32'(IFAdderOutput), 32'h0002);
        chk("rst_instr", 32'(Instruction),   32'h1120);
        chk("rst_ifid",  IFID_Output,        32'h0000_0000);
        chk("rst_rd1",   32'(rd1Read),       32'h0000);
        chk("rst_rd2",   32'(rd2Read),       32'h0000);
        chk("rst_r0",    32'(reg0Read),      32'h0000);
        reset_n = 1'b1;

        @(negedge clk);
        chk("e1_pc",    32'(PCOutput),    32'h0002);
        chk("e1_instr", 32'(Instruction), 32'h2340);
        chk("e1_ifid",  IFID_Output,      32'h0002_1120);
        chk("e1_rd1",   32'(rd1Read),     32'h1111);
        chk("e1_rd2",   32'(rd2Read),     32'h2222);
        chk("e1_r0",    32'(reg0Read),    32'h0000);

        @(negedge clk);
        chk("e2_pc",   32'(PCOutput), 32'h0004);
        chk("e2_ifid", IFID_Output,   32'h0004_2340);
        chk("e2_rd1",  32'(rd1Read),  32'h3333);
        chk("e2_rd2",  32'(rd2Read),  32'h4444);

        @(negedge clk);
        chk("e3_pc",    32'(PCOutput),    32'h0006);
        chk("e3_instr", 32'(Instruction), 32'h0000);
        chk("e3_ifid",  IFID_Output,      32'h0006_5670);
        chk("e3_rd1",   32'(rd1Read),     32'h6666);
        chk("e3_rd2",   32'(rd2Read),     32'h7777);
        chk("e3_r0",    32'(reg0Read),    32'h0000);

        @(posedge clk);
        #5 reset_n = 1'b0;
        #1;
        chk("mr_pc",    32'(PCOutput),      32'h0000);
        chk("mr_add",   32'(IFAdderOutput), 32'h0002);
        chk("mr_ifid",  IFID_Output,        32'h0000_0000);
        chk("mr_instr", 32'(Instruction),   32'h1120);
        chk("mr_rd1",   32'(rd1Read),       32'h0000);
        @(negedge clk);
        chk("mr_hold",  32'(PCOutput),      32'h0000);
        reset_n = 1'b1;
        @(negedge clk);
        chk("re1_pc",   32'(PCOutput),    32'h0002);
        chk("re1_ifid", IFID_Output,      32'h0002_1120);
        chk("re1_rd1",  32'(rd1Read),     32'h1111);

        #1 reset_n = 1'b0;
        #1 reset_n = 1'b1;
        chk("w_start", 32'(PCOutput), 32'h0000);
        for (int i = 0; i < 256; i++) begin
            @(negedge clk);
            chk("w_r0", 32'(reg0Read), 32'h0000);
        end
        chk("w_pc",    32'(PCOutput),    32'h0200);
        chk("w_instr", 32'(Instruction), 32'h1120);
        chk("w_ifid",  IFID_Output,      32'h0200_0000);

        for (int i = 256; i < 32767; i++) begin
            @(negedge clk);
            chk("l_r0", 32'(reg0Read), 32'h0000);
        end
        chk("f_pc",  32'(PCOutput),      32'hFFFE);
        chk("f_add", 32'(IFAdderOutput), 32'h0000);
        @(negedge clk);
        chk("z_pc",    32'(PCOutput),    32'h0000);
        chk("z_instr", 32'(Instruction), 32'h1120);
        chk("z_ifid",  IFID_Output,      32'h0000_0000);
        chk("z_r0",    32'(reg0Read),    32'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
